chaotic_decryption_core: RTL and testbench

- Receive-side counterpart of the hybrid chaotic encryption path.
- Accepts a key and a stream of ciphertext words.
- Regenerates the identical chaotic keystream with a fixed-point logistic map, warm-up and perturbation.
- XORs each ciphertext word with it to recover plaintext; valid/ready handshakes on both data sides, intended for the link sink / loopback checker.

---
 rtl/chaotic_decryption_core.sv | 205 ++++++++++++++++++++
 tb/tb_chaotic_decryption_core.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaotic_decryption_core.sv
// chaotic_decryption_core
// Receive-side chaotic stream decryptor. A key sets up a fixed-point
// logistic map. After a warm-up of k discarded steps, each ciphertext word
// is XORed with a keystream word taken from the map. After each word the map
// state is perturbed with alpha, so the encryption path and this block stay
// in lock-step.
//
// Handshake semantics (both data sides): a word moves on a rising edge where
// valid and ready are both high. The producer holds valid and its data
// stable until that edge. Ready may depend on state but never on the
// partner's valid. m_valid/m_plain are registered; s_ready is decoded from
// the current state only. A key strobe in the same cycle overrides any
// transfer, and that word is lost.

module chaotic_decryption_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DATA_WIDTH+1:0]   key,
  input  logic                      key_valid_in,
  input  logic [DATA_WIDTH-1:0]     s_cipher,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     m_plain,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CNT_WIDTH-1:0]      word_count,
  output logic [2:0]                fsm_state
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    READY  = 3'd2,
    GEN    = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state, state_next;

  // Key fields as they arrive on the bus
  logic [1:0]   key_sel;
  logic [W-1:0] key_mu;
  logic [W-1:0] key_alpha;
  logic [W-1:0] key_y0;
  logic [W-1:0] key_k;

  assign key_sel   = key[1:0];
  assign key_mu    = key[W+1:2];
  assign key_alpha = key[2*W+1:W+2];
  assign key_y0    = key[3*W+1:2*W+2];
  assign key_k     = key[4*W+1:3*W+2];

  // Latched key and map state
  logic [1:0]   sel_r;
  logic [W-1:0] mu_r;
  logic [W-1:0] alpha_r;
  logic [W-1:0] x;
  logic [W-1:0] cnt;
  logic [1:0]   iter;
  logic [W-1:0] cipher_r;

  // Map step datapath
  logic [W-1:0]  x_comp;
  logic [PW-1:0] product;
  logic [W-1:0]  x_step;

  // FSM control strobes
  logic accept;
  logic gen_last;
  logic deliver;

  // One logistic-map step: x' = (mu * x * (2^W-1-x)) >> (2W-2).
  // mu is Q2.(W-2) and x*(2^W-1-x) peaks near 2^(2W-2), so the shifted
  // product never needs more than W bits; the top two bits are always zero.
  always_comb begin
    x_comp  = {W{1'b1}} - x;
    product = PW'(mu_r) * PW'(x) * PW'(x_comp);
    x_step  = product[3*W-3 -: W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake strobes; a key strobe overrides all
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    gen_last   = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      WARMUP: begin
        // cnt is never zero here: k == 0 skips WARMUP entirely
        if (cnt == W'(1)) begin
          state_next = READY;
        end
      end
      READY: begin
        if (s_valid) begin
          accept     = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        if (iter == 2'd0) begin
          gen_last   = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          deliver    = 1'b1;
          state_next = READY;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (key_valid_in) begin
      accept     = 1'b0;
      gen_last   = 1'b0;
      deliver    = 1'b0;
      state_next = (key_k != '0) ? WARMUP : READY;
    end
  end

  // Ready is a pure function of state, never of s_valid
  assign s_ready   = (state == READY);
  assign fsm_state = state;

  // Key registers, map state, output word and delivered-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r      <= '0;
      mu_r       <= '0;
      alpha_r    <= '0;
      x          <= '0;
      cnt        <= '0;
      iter       <= '0;
      cipher_r   <= '0;
      m_plain    <= '0;
      m_valid    <= 1'b0;
      word_count <= '0;
    end else if (key_valid_in) begin
      sel_r      <= key_sel;
      mu_r       <= key_mu;
      alpha_r    <= key_alpha;
      x          <= key_y0;
      cnt        <= key_k;
      m_valid    <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        WARMUP: begin
          // Warm-up steps advance the map but produce no keystream
          x   <= x_step;
          cnt <= cnt - W'(1);
        end
        READY: begin
          if (accept) begin
            cipher_r <= s_cipher;
            iter     <= sel_r;
          end
        end
        GEN: begin
          if (gen_last) begin
            // Keystream is the fresh map output; alpha perturbs the state
            // only after the keystream word has been taken
            m_plain <= cipher_r ^ x_step;
            m_valid <= 1'b1;
            x       <= x_step ^ alpha_r;
          end else begin
            x    <= x_step;
            iter <= iter - 2'd1;
          end
        end
        OUT: begin
          if (deliver) begin
            m_valid    <= 1'b0;
            word_count <= word_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          x <= x;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chaotic_decryption_core.sv
// tb_chaotic_decryption_core
// Directed bench for the chaotic decryptor. The stimulus tasks push the
// expected plaintext into exp_q. A negedge monitor pops and compares every
// delivered word. Timing and stall properties are checked inline.

module tb_chaotic_decryption_core;

  localparam int W = 8;
  localparam int C = 16;

  logic             clk;
  logic             rst;
  logic [4*W+1:0]   key;
  logic             key_valid_in;
  logic [W-1:0]     s_cipher;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     m_plain;
  logic             m_valid;
  logic             m_ready;
  logic [C-1:0]     word_count;
  logic [2:0]       fsm_state;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  chaotic_decryption_core #(
    .DATA_WIDTH(W),
    .CNT_WIDTH (C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .key_valid_in(key_valid_in),
    .s_cipher    (s_cipher),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_plain     (m_plain),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .word_count  (word_count),
    .fsm_state   (fsm_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Independent logistic-map model written from the formula
  function automatic logic [W-1:0] map_step(input logic [W-1:0] mu, input logic [W-1:0] xv);
    int p;
    p = int'(mu) * int'(xv) * (255 - int'(xv));
    return W'(p >> 14);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] sel, input logic [W-1:0] mu,
                          input logic [W-1:0] alpha, input logic [W-1:0] y0,
                          input logic [W-1:0] k);
    key          = {k, y0, alpha, mu, sel};
    key_valid_in = 1'b1;
    tick();
    key_valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] c, input logic [W-1:0] pt, input bit push);
    int n;
    n        = 0;
    s_cipher = c;
    s_valid  = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fail_now("send_word s_ready");
      s_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(pt);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_s_ready(output int n);
    n = 0;
    while (!s_ready && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    tick();
  endtask

  // Scoreboard monitor: compare each delivered word against exp_q
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready && !key_valid_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected word: got %0h with empty queue", m_plain);
      end else begin
        check("plain", 32'(m_plain), 32'(exp_q.pop_front()));
      end
    end
  end

  // Main stimulus
  initial begin
    int n;
    int quiet;
    int held_v;
    int held_p;
    int held_r;
    logic [1:0]   sel;
    logic [W-1:0] mu, alpha, y0, k, xm, ks, pt;

    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    key          = '0;
    key_valid_in = 1'b0;
    s_cipher     = '0;
    s_valid      = 1'b0;
    m_ready      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset s_ready", 32'(s_ready), 0);
    check("reset m_valid", 32'(m_valid), 0);
    check("reset m_plain", 32'(m_plain), 0);
    check("reset word_count", 32'(word_count), 0);
    check("reset state", 32'(fsm_state), 0);

    // No key: ciphertext offered for 20 cycles must be refused
    s_valid = 1'b1;
    quiet   = 0;
    repeat (20) begin
      if (s_ready === 1'b0 && m_valid === 1'b0) quiet++;
      tick();
    end
    s_valid = 1'b0;
    check("idle no handshake", quiet, 20);
    check("idle word_count", 32'(word_count), 0);

    // mu=0: keystream zero, warm-up of 3 cycles
    load_key(2'd0, 8'h00, 8'h5A, 8'h33, 8'd3);
    wait_s_ready(n);
    check("warmup k3 cycles", n, 3);
    send_word(8'hA7, 8'hA7, 1'b1);
    wait_valid(n);
    check("latency sel0", n, 1);
    drain();

    // mu=0xFF, k=0: 64 -> 190 -> 192
    load_key(2'd0, 8'hFF, 8'h00, 8'h40, 8'd0);
    check("k0 ready at once", 32'(s_ready), 1);
    send_word(8'h00, 8'hBE, 1'b1);
    send_word(8'h00, 8'hC0, 1'b1);
    drain();
    check("word_count two", 32'(word_count), 2);

    // Perturbation: 64 -> 190 (ks), state 190^0x0F=177 -> 214 (ks)
    load_key(2'd0, 8'hFF, 8'h0F, 8'h40, 8'd0);
    send_word(8'h00, 8'hBE, 1'b1);
    send_word(8'h00, 8'hD6, 1'b1);
    drain();
    check("word_count after alpha", 32'(word_count), 2);

    // sel=3 with downstream stall: 64->190->192->188->196, 0x3C^0xC4=0xF8
    m_ready = 1'b0;
    load_key(2'd3, 8'hFF, 8'h00, 8'h40, 8'd0);
    send_word(8'h3C, 8'hF8, 1'b1);
    wait_valid(n);
    check("latency sel3", n, 4);
    held_v = 0;
    held_p = 0;
    held_r = 0;
    repeat (10) begin
      if (m_valid === 1'b1) held_v++;
      if (m_plain === 8'hF8) held_p++;
      if (s_ready === 1'b0) held_r++;
      tick();
    end
    check("stall m_valid held", held_v, 10);
    check("stall m_plain held", held_p, 10);
    check("stall s_ready low", held_r, 10);
    m_ready = 1'b1;
    drain();
    check("word_count after stall", 32'(word_count), 1);

    // Key strobe in OUT together with m_ready: word dropped, restart
    load_key(2'd0, 8'hFF, 8'h00, 8'h40, 8'd0);
    send_word(8'h00, 8'hBE, 1'b1);
    drain();
    m_ready = 1'b0;
    send_word(8'h11, 8'h00, 1'b0);
    wait_valid(n);
    if (n >= 50) fail_now("pending word before key strobe");
    m_ready = 1'b1;
    // New key y0=0x80, k=2: warm-up 128->253->7, keystream 27
    load_key(2'd0, 8'hFF, 8'h00, 8'h80, 8'd2);
    check("strobe drops m_valid", 32'(m_valid), 0);
    check("strobe clears word_count", 32'(word_count), 0);
    check("strobe enters warmup", 32'(fsm_state), 1);
    wait_s_ready(n);
    check("warmup k2 cycles", n, 2);
    send_word(8'h00, 8'h1B, 1'b1);
    drain();
    check("word_count after restart", 32'(word_count), 1);

    // Reset while a word is pending
    m_ready = 1'b0;
    send_word(8'h55, 8'h00, 1'b0);
    wait_valid(n);
    if (n >= 50) fail_now("pending word before reset");
    rst = 1'b1;
    tick();
    check("midrst m_valid", 32'(m_valid), 0);
    check("midrst m_plain", 32'(m_plain), 0);
    check("midrst word_count", 32'(word_count), 0);
    check("midrst state", 32'(fsm_state), 0);
    rst = 1'b0;
    m_ready = 1'b1;
    tick();

    // Loopback: random keys, 4 x 64 words through the encryption model
    for (int kk = 0; kk < 4; kk++) begin
      sel   = 2'($urandom_range(0, 3));
      mu    = 8'($urandom_range(0, 255));
      alpha = 8'($urandom_range(0, 255));
      y0    = 8'($urandom_range(0, 255));
      k     = 8'($urandom_range(0, 6));
      load_key(sel, mu, alpha, y0, k);
      xm = y0;
      for (int i = 0; i < int'(k); i++) xm = map_step(mu, xm);
      for (int wi = 0; wi < 64; wi++) begin
        pt = 8'($urandom_range(0, 255));
        for (int s = 0; s <= int'(sel); s++) xm = map_step(mu, xm);
        ks = xm;
        xm = ks ^ alpha;
        send_word(pt ^ ks, pt, 1'b1);
      end
      drain();
      check("loopback word_count", 32'(word_count), 64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
